// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter state/owner types for the fetch/LSU bus arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Opcode fetch, privileged for IFU; data access, privileged for LSU.
    localparam logic [3:0] HPROT_IFU = 4'b0010;
    localparam logic [3:0] HPROT_LSU = 4'b0011;

    // One-hot so the arbiter FSM decodes the same way as the PFU FSM.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ADDR = 3'b010,
        ST_DATA = 3'b100
    } arb_state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ahb_prio_starve.sv
// Fixed LSU-priority arbitration with an anti-starvation counter for the IFU.
module ahb_prio_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic arb_en,
    input  logic ifu_req,
    input  logic ifu_kill,
    input  logic lsu_req,
    output logic grant_ifu,
    output logic grant_lsu
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          ifu_starved;

    // LSU wins unless the IFU has lost LIMIT times in a row and is still asking.
    always_comb begin
        ifu_starved = ifu_req && (starve_cnt == LIMIT);
        grant_lsu   = arb_en && lsu_req && !ifu_starved;
        grant_ifu   = arb_en && !(lsu_req && !ifu_starved) && ifu_req && !ifu_kill;
    end

    // Count IFU losses; any IFU win or an arbitration cycle without an IFU request resets the count.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (grant_ifu || !ifu_req) begin
                starve_cnt <= '0;
            end else if (grant_lsu && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ahb_fetch_lsu_arbiter.sv
// Shares one AHB-Lite master port between instruction fetch and load/store,
// issuing one non-pipelined SINGLE transfer at a time with fully registered outputs.
module ahb_fetch_lsu_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ifu_req_i,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    input  logic              ifu_kill_i,
    output logic              ifu_ack_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_err_o,
    input  logic              lsu_req_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic              lsu_wr_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_ack_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_err_o,
    output logic [ADDR_W-1:0] haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [2:0]        hburst_o,
    output logic [3:0]        hprot_o,
    output logic [DATA_W-1:0] hwdata_o,
    input  logic              hready_i,
    input  logic              hresp_i,
    input  logic [DATA_W-1:0] hrdata_i
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              kill_pend_q, kill_pend_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [ADDR_W-1:0] haddr_d;
    logic [1:0]        htrans_d;
    logic              hwrite_d;
    logic [2:0]        hsize_d;
    logic [3:0]        hprot_d;
    logic [DATA_W-1:0] hwdata_d;

    logic              ifu_ack_d, ifu_err_d, lsu_ack_d, lsu_err_d;
    logic [DATA_W-1:0] ifu_rdata_d, lsu_rdata_d;

    logic              grant_ifu, grant_lsu;

    assign hburst_o = HBURST_SINGLE;

    ahb_prio_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .arb_en    (state_q == ST_IDLE),
        .ifu_req   (ifu_req_i),
        .ifu_kill  (ifu_kill_i),
        .lsu_req   (lsu_req_i),
        .grant_ifu (grant_ifu),
        .grant_lsu (grant_lsu)
    );

    // Next-state and next-output logic; every output is held unless a phase change updates it.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_pend_d = kill_pend_q;
        wdata_d     = wdata_q;
        haddr_d     = haddr_o;
        htrans_d    = htrans_o;
        hwrite_d    = hwrite_o;
        hsize_d     = hsize_o;
        hprot_d     = hprot_o;
        hwdata_d    = hwdata_o;
        ifu_ack_d   = 1'b0;
        ifu_err_d   = 1'b0;
        ifu_rdata_d = ifu_rdata_o;
        lsu_ack_d   = 1'b0;
        lsu_err_d   = 1'b0;
        lsu_rdata_d = lsu_rdata_o;

        unique case (state_q)
            ST_IDLE: begin
                htrans_d    = HTRANS_IDLE;
                kill_pend_d = 1'b0;
                if (grant_lsu) begin
                    owner_d  = OWNER_LSU;
                    haddr_d  = lsu_addr_i;
                    hwrite_d = lsu_wr_i;
                    hsize_d  = lsu_size_i;
                    hprot_d  = HPROT_LSU;
                    wdata_d  = lsu_wdata_i;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ST_ADDR;
                end else if (grant_ifu) begin
                    owner_d  = OWNER_IFU;
                    haddr_d  = ifu_addr_i;
                    hwrite_d = 1'b0;
                    hsize_d  = HSIZE_WORD;
                    hprot_d  = HPROT_IFU;
                    wdata_d  = '0;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (ifu_kill_i && (owner_q == OWNER_IFU)) begin
                    kill_pend_d = 1'b1;
                end
                if (hready_i) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = ST_DATA;
                end
            end

            ST_DATA: begin
                if (ifu_kill_i && (owner_q == OWNER_IFU)) begin
                    kill_pend_d = 1'b1;
                end
                if (hready_i) begin
                    state_d     = ST_IDLE;
                    hwdata_d    = '0;
                    kill_pend_d = 1'b0;
                    if (owner_q == OWNER_LSU) begin
                        lsu_ack_d   = 1'b1;
                        lsu_rdata_d = hrdata_i;
                        lsu_err_d   = hresp_i;
                    end else if (!(kill_pend_q || ifu_kill_i)) begin
                        ifu_ack_d   = 1'b1;
                        ifu_rdata_d = hrdata_i;
                        ifu_err_d   = hresp_i;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in progress without an ack.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_IFU;
            kill_pend_q <= 1'b0;
            wdata_q     <= '0;
            haddr_o     <= '0;
            htrans_o    <= HTRANS_IDLE;
            hwrite_o    <= 1'b0;
            hsize_o     <= HSIZE_WORD;
            hprot_o     <= 4'b0000;
            hwdata_o    <= '0;
            ifu_ack_o   <= 1'b0;
            ifu_err_o   <= 1'b0;
            ifu_rdata_o <= '0;
            lsu_ack_o   <= 1'b0;
            lsu_err_o   <= 1'b0;
            lsu_rdata_o <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_pend_q <= kill_pend_d;
            wdata_q     <= wdata_d;
            haddr_o     <= haddr_d;
            htrans_o    <= htrans_d;
            hwrite_o    <= hwrite_d;
            hsize_o     <= hsize_d;
            hprot_o     <= hprot_d;
            hwdata_o    <= hwdata_d;
            ifu_ack_o   <= ifu_ack_d;
            ifu_err_o   <= ifu_err_d;
            ifu_rdata_o <= ifu_rdata_d;
            lsu_ack_o   <= lsu_ack_d;
            lsu_err_o   <= lsu_err_d;
            lsu_rdata_o <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_fetch_lsu_arbiter.sv
// Directed testbench for the AHB fetch/LSU arbiter with hand-computed expectations.
module tb_ahb_fetch_lsu_arbiter;

    logic        clk_i;
    logic        rst_n_i;
    logic        ifu_req_i;
    logic [31:0] ifu_addr_i;
    logic        ifu_kill_i;
    logic        ifu_ack_o;
    logic [31:0] ifu_rdata_o;
    logic        ifu_err_o;
    logic        lsu_req_i;
    logic [31:0] lsu_addr_i;
    logic        lsu_wr_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ack_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic [31:0] haddr_o;
    logic [1:0]  htrans_o;
    logic        hwrite_o;
    logic [2:0]  hsize_o;
    logic [2:0]  hburst_o;
    logic [3:0]  hprot_o;
    logic [31:0] hwdata_o;
    logic        hready_i;
    logic        hresp_i;
    logic [31:0] hrdata_i;

    int errors = 0;
    int checks = 0;

    // Expected owner of each grant with both requesters held: 1 = LSU, 0 = IFU.
    int exp_lsu [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    ahb_fetch_lsu_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .ifu_req_i   (ifu_req_i),
        .ifu_addr_i  (ifu_addr_i),
        .ifu_kill_i  (ifu_kill_i),
        .ifu_ack_o   (ifu_ack_o),
        .ifu_rdata_o (ifu_rdata_o),
        .ifu_err_o   (ifu_err_o),
        .lsu_req_i   (lsu_req_i),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_wr_i    (lsu_wr_i),
        .lsu_size_i  (lsu_size_i),
        .lsu_wdata_i (lsu_wdata_i),
        .lsu_ack_o   (lsu_ack_o),
        .lsu_rdata_o (lsu_rdata_o),
        .lsu_err_o   (lsu_err_o),
        .haddr_o     (haddr_o),
        .htrans_o    (htrans_o),
        .hwrite_o    (hwrite_o),
        .hsize_o     (hsize_o),
        .hburst_o    (hburst_o),
        .hprot_o     (hprot_o),
        .hwdata_o    (hwdata_o),
        .hready_i    (hready_i),
        .hresp_i     (hresp_i),
        .hrdata_i    (hrdata_i)
    );

    // 10 ns free-running clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one cycle; drive and sample 1 ns after the rising edge.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0;
        tick;
        tick;
        checks++; if (htrans_o !== 2'b00) begin errors++; $display("[TB] FAIL rst_htrans got=%0h exp=0", htrans_o); end
        checks++; if (haddr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_haddr got=%0h exp=0", haddr_o); end
        checks++; if (hwrite_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_hwrite got=%0b exp=0", hwrite_o); end
        checks++; if (hsize_o !== 3'b010) begin errors++; $display("[TB] FAIL rst_hsize got=%0h exp=2", hsize_o); end
        checks++; if (hprot_o !== 4'b0000) begin errors++; $display("[TB] FAIL rst_hprot got=%0h exp=0", hprot_o); end
        checks++; if (hburst_o !== 3'b000) begin errors++; $display("[TB] FAIL rst_hburst got=%0h exp=0", hburst_o); end
        checks++; if (hwdata_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_hwdata got=%0h exp=0", hwdata_o); end
        checks++; if (ifu_ack_o !== 1'b0 || lsu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_acks got=%0b%0b exp=00", ifu_ack_o, lsu_ack_o); end
        checks++; if (ifu_err_o !== 1'b0 || lsu_err_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_errs got=%0b%0b exp=00", ifu_err_o, lsu_err_o); end
        checks++; if (ifu_rdata_o !== 32'h0 || lsu_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got=%0h/%0h exp=0/0", ifu_rdata_o, lsu_rdata_o); end
        rst_n_i = 1'b1;
        tick;
    endtask

    task automatic test_ifu_fetch;
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h0000_0100;
        hrdata_i   = 32'h0000_0013;
        hready_i   = 1'b1;
        hresp_i    = 1'b0;
        tick;
        checks++; if (htrans_o !== 2'b10) begin errors++; $display("[TB] FAIL ifu_nonseq got=%0h exp=2", htrans_o); end
        checks++; if (haddr_o !== 32'h0000_0100) begin errors++; $display("[TB] FAIL ifu_haddr got=%0h exp=100", haddr_o); end
        checks++; if (hprot_o !== 4'b0010 || hwrite_o !== 1'b0 || hsize_o !== 3'b010) begin errors++; $display("[TB] FAIL ifu_ctrl got=prot%0h wr%0b sz%0h exp=prot2 wr0 sz2", hprot_o, hwrite_o, hsize_o); end
        tick;
        checks++; if (htrans_o !== 2'b00 || ifu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL ifu_data_phase got=htrans%0h ack%0b exp=htrans0 ack0", htrans_o, ifu_ack_o); end
        tick;
        checks++; if (ifu_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL ifu_ack got=%0b exp=1", ifu_ack_o); end
        checks++; if (ifu_rdata_o !== 32'h0000_0013 || ifu_err_o !== 1'b0) begin errors++; $display("[TB] FAIL ifu_rdata got=%0h err%0b exp=13 err0", ifu_rdata_o, ifu_err_o); end
        checks++; if (lsu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL ifu_wrong_ack got=%0b exp=0", lsu_ack_o); end
        ifu_req_i = 1'b0;
        tick;
        checks++; if (ifu_ack_o !== 1'b0 || htrans_o !== 2'b00) begin errors++; $display("[TB] FAIL ifu_after got=ack%0b htrans%0h exp=ack0 htrans0", ifu_ack_o, htrans_o); end
    endtask

    task automatic test_lsu_write_wait;
        lsu_req_i   = 1'b1;
        lsu_wr_i    = 1'b1;
        lsu_addr_i  = 32'h2000_0004;
        lsu_size_i  = 3'd2;
        lsu_wdata_i = 32'hDEAD_BEEF;
        hready_i    = 1'b1;
        tick;
        checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h2000_0004) begin errors++; $display("[TB] FAIL lsuw_addr got=htrans%0h addr%0h exp=htrans2 addr20000004", htrans_o, haddr_o); end
        checks++; if (hwrite_o !== 1'b1 || hsize_o !== 3'd2 || hprot_o !== 4'b0011) begin errors++; $display("[TB] FAIL lsuw_ctrl got=wr%0b sz%0h prot%0h exp=wr1 sz2 prot3", hwrite_o, hsize_o, hprot_o); end
        checks++; if (hwdata_o !== 32'h0) begin errors++; $display("[TB] FAIL lsuw_wdata_early got=%0h exp=0", hwdata_o); end
        tick;
        checks++; if (hwdata_o !== 32'hDEAD_BEEF || htrans_o !== 2'b00) begin errors++; $display("[TB] FAIL lsuw_data got=wdata%0h htrans%0h exp=wdatadeadbeef htrans0", hwdata_o, htrans_o); end
        hready_i = 1'b0;
        tick;
        checks++; if (lsu_ack_o !== 1'b0 || hwdata_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL lsuw_wait1 got=ack%0b wdata%0h exp=ack0 wdatadeadbeef", lsu_ack_o, hwdata_o); end
        tick;
        checks++; if (lsu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL lsuw_wait2 got=%0b exp=0", lsu_ack_o); end
        hready_i = 1'b1;
        tick;
        checks++; if (lsu_ack_o !== 1'b1 || lsu_err_o !== 1'b0) begin errors++; $display("[TB] FAIL lsuw_ack got=ack%0b err%0b exp=ack1 err0", lsu_ack_o, lsu_err_o); end
        checks++; if (ifu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL lsuw_wrong_ack got=%0b exp=0", ifu_ack_o); end
        lsu_req_i = 1'b0;
        lsu_wr_i  = 1'b0;
        tick;
        checks++; if (lsu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL lsuw_ack_pulse got=%0b exp=0", lsu_ack_o); end
    endtask

    task automatic test_lsu_error;
        lsu_req_i  = 1'b1;
        lsu_wr_i   = 1'b0;
        lsu_addr_i = 32'h3000_0000;
        lsu_size_i = 3'd2;
        hready_i   = 1'b1;
        hresp_i    = 1'b0;
        tick;
        checks++; if (htrans_o !== 2'b10 || hwrite_o !== 1'b0 || haddr_o !== 32'h3000_0000) begin errors++; $display("[TB] FAIL lsue_addr got=htrans%0h wr%0b addr%0h exp=htrans2 wr0 addr30000000", htrans_o, hwrite_o, haddr_o); end
        tick;
        hready_i = 1'b0;
        hresp_i  = 1'b1;
        tick;
        checks++; if (lsu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL lsue_first_cycle got=%0b exp=0", lsu_ack_o); end
        hready_i = 1'b1;
        hrdata_i = 32'hBAD0_0000;
        tick;
        checks++; if (lsu_ack_o !== 1'b1 || lsu_err_o !== 1'b1) begin errors++; $display("[TB] FAIL lsue_ack got=ack%0b err%0b exp=ack1 err1", lsu_ack_o, lsu_err_o); end
        lsu_req_i = 1'b0;
        hresp_i   = 1'b0;
        tick;
        checks++; if (lsu_err_o !== 1'b0 || lsu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL lsue_clear got=ack%0b err%0b exp=ack0 err0", lsu_ack_o, lsu_err_o); end
    endtask

    task automatic test_ifu_kill;
        ifu_req_i  = 1'b1;
        ifu_kill_i = 1'b1;
        ifu_addr_i = 32'h0000_0200;
        hrdata_i   = 32'h0000_0055;
        hready_i   = 1'b1;
        tick;
        checks++; if (htrans_o !== 2'b00) begin errors++; $display("[TB] FAIL kill_idle_block got=%0h exp=0", htrans_o); end
        ifu_kill_i = 1'b0;
        tick;
        checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h0000_0200) begin errors++; $display("[TB] FAIL kill_grant got=htrans%0h addr%0h exp=htrans2 addr200", htrans_o, haddr_o); end
        tick;
        hready_i   = 1'b0;
        ifu_kill_i = 1'b1;
        ifu_req_i  = 1'b0;
        tick;
        ifu_kill_i = 1'b0;
        hready_i   = 1'b1;
        checks++; if (ifu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL kill_wait_ack got=%0b exp=0", ifu_ack_o); end
        tick;
        checks++; if (ifu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL kill_suppress got=%0b exp=0", ifu_ack_o); end
        checks++; if (htrans_o !== 2'b00) begin errors++; $display("[TB] FAIL kill_bus_idle got=%0h exp=0", htrans_o); end
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h0000_0204;
        hrdata_i   = 32'h0000_0077;
        tick;
        checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h0000_0204) begin errors++; $display("[TB] FAIL kill_refetch got=htrans%0h addr%0h exp=htrans2 addr204", htrans_o, haddr_o); end
        tick;
        tick;
        checks++; if (ifu_ack_o !== 1'b1 || ifu_rdata_o !== 32'h0000_0077) begin errors++; $display("[TB] FAIL kill_refetch_ack got=ack%0b rdata%0h exp=ack1 rdata77", ifu_ack_o, ifu_rdata_o); end
        ifu_req_i = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        lsu_req_i  = 1'b1;
        lsu_wr_i   = 1'b0;
        lsu_addr_i = 32'h5000_0000;
        lsu_size_i = 3'd2;
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h0000_0400;
        hready_i   = 1'b1;
        tick;
        tick;
        tick;
        tick;
        checks++; if (htrans_o !== 2'b10 || hprot_o !== 4'b0011) begin errors++; $display("[TB] FAIL rmid_second_lsu got=htrans%0h prot%0h exp=htrans2 prot3", htrans_o, hprot_o); end
        hready_i = 1'b0;
        tick;
        checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h5000_0000) begin errors++; $display("[TB] FAIL rmid_addr_hold got=htrans%0h addr%0h exp=htrans2 addr50000000", htrans_o, haddr_o); end
        checks++; if (dut.u_prio.starve_cnt !== 3'd2) begin errors++; $display("[TB] FAIL rmid_cnt_before got=%0d exp=2", dut.u_prio.starve_cnt); end
        rst_n_i   = 1'b0;
        lsu_req_i = 1'b0;
        ifu_req_i = 1'b0;
        tick;
        rst_n_i  = 1'b1;
        hready_i = 1'b1;
        checks++; if (htrans_o !== 2'b00) begin errors++; $display("[TB] FAIL rmid_htrans got=%0h exp=0", htrans_o); end
        checks++; if (dut.u_prio.starve_cnt !== 3'd0) begin errors++; $display("[TB] FAIL rmid_cnt got=%0d exp=0", dut.u_prio.starve_cnt); end
        checks++; if (lsu_ack_o !== 1'b0 || ifu_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ack got=%0b%0b exp=00", ifu_ack_o, lsu_ack_o); end
        tick;
        checks++; if (lsu_ack_o !== 1'b0 || htrans_o !== 2'b00) begin errors++; $display("[TB] FAIL rmid_after got=ack%0b htrans%0h exp=ack0 htrans0", lsu_ack_o, htrans_o); end
        tick;
    endtask

    task automatic test_starvation;
        int n;
        n = 0;
        lsu_req_i  = 1'b1;
        lsu_wr_i   = 1'b0;
        lsu_addr_i = 32'h4000_0000;
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h0000_0300;
        hready_i   = 1'b1;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick;
            if (htrans_o === 2'b10) begin
                checks++;
                if (hprot_o[0] !== exp_lsu[n][0]) begin
                    errors++;
                    $display("[TB] FAIL starve_grant%0d got=owner%0b exp=owner%0b", n, hprot_o[0], exp_lsu[n][0]);
                end
                n++;
            end
        end
        checks++; if (n != 10) begin errors++; $display("[TB] FAIL starve_timeout got=%0d grants exp=10", n); end
        lsu_req_i = 1'b0;
        ifu_req_i = 1'b0;
        for (int c = 0; c < 4; c++) tick;
        checks++; if (htrans_o !== 2'b00) begin errors++; $display("[TB] FAIL starve_drain got=%0h exp=0", htrans_o); end
    endtask

    // Scenario sequence.
    initial begin
        rst_n_i     = 1'b0;
        ifu_req_i   = 1'b0;
        ifu_addr_i  = '0;
        ifu_kill_i  = 1'b0;
        lsu_req_i   = 1'b0;
        lsu_addr_i  = '0;
        lsu_wr_i    = 1'b0;
        lsu_size_i  = 3'd2;
        lsu_wdata_i = '0;
        hready_i    = 1'b1;
        hresp_i     = 1'b0;
        hrdata_i    = '0;

        test_reset();
        test_ifu_fetch();
        test_lsu_write_wait();
        test_lsu_error();
        test_ifu_kill();
        test_reset_mid();
        test_starvation();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_fetch_lsu_arbiter.md
Name: ahb_fetch_lsu_arbiter

Overview:
- Shares the single AHB-Lite master port between the instruction-fetch requester (PFU) and the load/store requester (LSU).
- Arbitrates with fixed LSU priority plus an IFU anti-starvation counter.
- Issues one non-pipelined SINGLE transfer at a time and returns read data and error status to the winner.
- Sits between PFU/LSU and the system AHB interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive IFU losses after which IFU wins the next arbitration (must be ≥1).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; synchronous, active-low.
- ifu_req_i  in  1  fetch request; held until ifu_ack_o or ifu_kill_i.
- ifu_addr_i  in  ADDR_W  fetch address (word aligned).
- ifu_kill_i  in  1  flush: discard the in-flight or pending IFU request.
- ifu_ack_o  out  1  one-cycle completion pulse.
- ifu_rdata_o  out  DATA_W  fetched word, valid with ifu_ack_o.
- ifu_err_o  out  1  bus error, valid with ifu_ack_o.
- lsu_req_i  in  1  data request; held until lsu_ack_o.
- lsu_addr_i  in  ADDR_W  data address.
- lsu_wr_i  in  1  1 = write.
- lsu_size_i  in  3  HSIZE encoding (0 byte, 1 half, 2 word).
- lsu_wdata_i  in  DATA_W  write data.
- lsu_ack_o  out  1  one-cycle completion pulse.
- lsu_rdata_o  out  DATA_W  read data, valid with lsu_ack_o.
- lsu_err_o  out  1  bus error, valid with lsu_ack_o.
- haddr_o  out  ADDR_W  AHB address.
- htrans_o  out  2  AHB transfer type.
- hwrite_o  out  1  AHB write.
- hsize_o  out  3  AHB size.
- hburst_o  out  3  constant 3'b000 (SINGLE).
- hprot_o  out  4  4'b0010 for IFU (opcode fetch, privileged); 4'b0011 for LSU.
- hwdata_o  out  DATA_W  AHB write data.
- hready_i  in  1  AHB ready.
- hresp_i  in  1  AHB response (1 = ERROR).
- hrdata_i  in  DATA_W  AHB read data.

Behaviour:
- States: IDLE, ADDR, DATA. All outputs are registered.
- Reset values: state=IDLE, htrans_o=2'b00, haddr_o/hwdata_o/rdata=0, hwrite_o=0, hsize_o=3'b010, hprot_o=0, acks=0, errs=0, starve_cnt=0, owner=IFU, kill_pend=0.
- Reset asserted mid-transfer aborts immediately to IDLE with no ack. Slave-side recovery is the interconnect's responsibility.
- IDLE, no request: stay; htrans=IDLE.
- IDLE, arbitration (single cycle):
  - Winner is LSU if lsu_req_i and not (ifu_req_i and starve_cnt==STARVE_LIMIT); otherwise IFU if ifu_req_i & ~ifu_kill_i.
  - Latch the winner's address, size (IFU forces 3'b010, write=0), write flag, wdata and owner; go to ADDR.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) each grant to LSU while ifu_req_i=1.
  - Cleared on any grant to IFU, or on an IDLE cycle with ifu_req_i=0.
- ADDR:
  - htrans=NONSEQ with the latched haddr/hwrite/hsize/hprot.
  - On hready_i=1 go to DATA with htrans=IDLE; hwdata_o = latched wdata.
  - On hready_i=0 hold everything.
- DATA, hready_i=1: capture hrdata_i and hresp_i; next cycle pulse the owner's ack for one cycle with rdata/err; go to IDLE.
- DATA, hready_i=0: wait. The first error cycle (hready=0, hresp=1) is a wait; the error is sampled on the hready=1 cycle.
- Latency: request→NONSEQ on bus = 1 cycle; with zero-wait slave, request→ack = 3 cycles. An ack cycle is also an IDLE/arbitration cycle.
- The requester must drop or renew req in the ack cycle. A req still high in the ack cycle is treated as a new request.
- ifu_kill_i while owner=IFU in ADDR or DATA: bus transfer completes normally, kill_pend set, ifu_ack_o suppressed; kill_pend is cleared at the transfer's end.
- ifu_kill_i in IDLE blocks the IFU grant that cycle.
- Both requests with starve_cnt<STARVE_LIMIT → LSU. Equal to limit → IFU.
- No back-to-back pipelining: at most one transfer outstanding.
- Write data is driven only in the DATA phase.

Decomposition:
- Shared package (ahb_pkg): HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_BYTE/HALF/WORD, HPROT_IFU/HPROT_LSU, and the state encoding (one-hot, matching the PFU FSM style).
- Natural sub-module: ahb_prio_starve (combinational priority plus the starve counter).

Test Plan:
- ifu_req=1, addr=0x0000_0100, slave zero-wait, hrdata=0x0000_0013 → NONSEQ at cycle 1; ifu_ack=1 at cycle 3 with rdata=0x13, err=0.
- lsu_req write addr=0x2000_0004, size=2, wdata=0xDEADBEEF, slave inserts 2 wait states in DATA → hwrite=1 and hsize=2 in ADDR; hwdata=0xDEADBEEF in DATA; lsu_ack after hready=1.
- Both requests held continuously, STARVE_LIMIT=4 → grant order L,L,L,L,I,L,L,L,L,I…
- LSU read at 0x3000_0000, slave returns ERROR (hready=0/hresp=1 then hready=1/hresp=1) → lsu_ack=1, lsu_err=1.
- ifu_kill_i pulsed while an IFU transfer is in DATA → transfer completes on bus, no ifu_ack; next IDLE grants a new IFU request normally.
- rst_n_i=0 for 1 cycle during ADDR with hready=0 → next cycle htrans=IDLE, no ack, starve_cnt=0.
